// File: rtl/mc_recon.sv
// Motion-compensated reconstruction of one 16x16 luma macroblock: reference fetch + residual add.
// Optional residual path enabled by MC_RECON_RESIDUAL_EN; otherwise a pure prediction copy.
module mc_recon #(
    parameter int WIDTH  = 352,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ref_start_addr,
    input  logic [31:0] dst_start_addr,
    input  logic [31:0] mb_x_pos,
    input  logic [31:0] mb_y_pos,
    input  logic [5:0]  mv_x,
    input  logic [5:0]  mv_y,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        res_valid,
    input  logic [8:0]  res_data,
    output logic        res_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LATCH, RUN, DONE} state_t;

    localparam logic [31:0]        W32   = 32'(WIDTH);
    localparam logic signed [31:0] X_MAX = 32'(WIDTH - 16);
    localparam logic signed [31:0] Y_MAX = 32'(HEIGHT - 16);

    function automatic logic signed [31:0] clamp_s32(input logic signed [31:0] v,
                                                     input logic signed [31:0] lo,
                                                     input logic signed [31:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    state_t      state, state_nxt;
    logic [8:0]  pixel_cnt;
    logic [31:0] lat_ref, lat_dst, lat_mb_x, lat_mb_y;
    logic [5:0]  lat_mv_x, lat_mv_y;

    logic signed [31:0] mv_x_c, mv_y_c, rx, ry;
    logic [31:0] row_off, col_off;
    logic        consume;
    logic [9:0]  res_ext, sum;
    logic        unused_ok;

    assign mv_x_c  = clamp_s32({{26{lat_mv_x[5]}}, lat_mv_x}, -32'sd16, 32'sd16);
    assign mv_y_c  = clamp_s32({{26{lat_mv_y[5]}}, lat_mv_y}, -32'sd16, 32'sd16);
    assign rx      = clamp_s32(lat_mb_x + mv_x_c, 32'sd0, X_MAX);
    assign ry      = clamp_s32(lat_mb_y + mv_y_c, 32'sd0, Y_MAX);
    assign row_off = 32'(pixel_cnt[7:4]) * W32;
    assign col_off = 32'(pixel_cnt[3:0]);

`ifdef MC_RECON_RESIDUAL_EN
    assign consume   = (state == RUN) && res_valid;
    assign res_ready = (state == RUN);
    assign res_ext   = {res_data[8], res_data};
    assign unused_ok = pixel_cnt[8];
`else
    // Prediction-only build: the residual stream is never accepted.
    assign consume   = (state == RUN);
    assign res_ready = 1'b0;
    assign res_ext   = '0;
    assign unused_ok = ^{pixel_cnt[8], res_valid, res_data};
`endif

    // 10-bit signed sum spans -256..510, so bit 9 flags negative and bit 8 flags overflow.
    assign sum = {2'b00, mem_rdata} + res_ext;

    assign mem_addr = (state == RUN)
                    ? lat_ref + $unsigned(ry) * W32 + $unsigned(rx) + row_off + col_off
                    : '0;
    assign wr_en    = consume;
    assign wr_addr  = consume ? lat_dst + lat_mb_y * W32 + lat_mb_x + row_off + col_off : '0;
    assign wr_data  = !consume ? 8'h00 : sum[9] ? 8'h00 : sum[8] ? 8'hFF : sum[7:0];
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = LATCH;
            LATCH: state_nxt = RUN;
            RUN:   if (consume && pixel_cnt[7:0] == 8'hFF) state_nxt = DONE;
            DONE:  if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pixel_cnt <= '0;
            lat_ref   <= '0;
            lat_dst   <= '0;
            lat_mb_x  <= '0;
            lat_mb_y  <= '0;
            lat_mv_x  <= '0;
            lat_mv_y  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_nxt;
            if (state == LATCH) begin
                lat_ref   <= ref_start_addr;
                lat_dst   <= dst_start_addr;
                lat_mb_x  <= mb_x_pos;
                lat_mb_y  <= mb_y_pos;
                lat_mv_x  <= mv_x;
                lat_mv_y  <= mv_y;
                pixel_cnt <= '0;
            end else if (consume) begin
                pixel_cnt <= pixel_cnt + 9'd1;
            end
        end
    end

endmodule

// File: doc/mc_recon.md
MC_RECON -- requirements
Module: mc_recon

Interface
REQ-001 Parameter: WIDTH, 352, luma frame width in pixels.
REQ-002 Parameter: HEIGHT, 240, luma frame height in pixels.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level request; sampled only in IDLE.
REQ-006 ref_start_addr  in  32  base byte address of reference frame.
REQ-007 dst_start_addr  in  32  base byte address of reconstructed output frame.
REQ-008 mb_x_pos, mb_y_pos  in  32 each  top-left pixel of the 16x16 macroblock.
REQ-009 mv_x, mv_y  in  6 each, signed  motion vector from the hexagon search.
REQ-010 mem_addr  out  32  reference read address; mem_rdata is valid in the same cycle.
REQ-011 mem_rdata  in  8  reference pixel.
REQ-012 res_valid  in  1; res_data  in  9 signed; res_ready  out  1  residual stream, raster order.
REQ-013 wr_en  out  1; wr_addr  out  32; wr_data  out  8  reconstructed-pixel write port.
REQ-014 busy  out  1  high outside IDLE.
REQ-015 done  out  1  completion flag, held until start is low.

Function
REQ-016 States SHALL be IDLE, LATCH, RUN, DONE.
REQ-017 IDLE->LATCH SHALL occur on start=1; LATCH SHALL register mb_x_pos, mb_y_pos, mv_x, mv_y, ref_start_addr and dst_start_addr, clear pixel_cnt (9 bit), then go to RUN; input changes after LATCH have no effect.
REQ-018 The latched MV SHALL be clamped to [-16,+16] per axis before use.
REQ-019 Reference origin: rx=mb_x+mv_x clamped to [0,WIDTH-16]; ry=mb_y+mv_y clamped to [0,HEIGHT-16], computed in signed 32-bit arithmetic.
REQ-020 In RUN, mem_addr SHALL be ref_start_addr+ry*WIDTH+rx+pixel_cnt[7:4]*WIDTH+pixel_cnt[3:0]; in all other states it is 0.
REQ-021 res_ready SHALL be 1 exactly in RUN; a pixel SHALL be consumed on a cycle with RUN and res_valid=1.
REQ-022 On a consumed pixel: wr_en=1, wr_addr=dst_start_addr+mb_y*WIDTH+mb_x+pixel_cnt[7:4]*WIDTH+pixel_cnt[3:0] (unclamped MB origin), wr_data=clip(mem_rdata+res_data,0,255); pixel_cnt then increments.
REQ-023 res_valid=0 in RUN SHALL stall: wr_en=0, pixel_cnt held, mem_addr stable.
REQ-024 wr_en, wr_addr and wr_data SHALL be combinational from state, pixel_cnt and res_valid; wr_en=0 outside RUN.
REQ-025 The consume of pixel 255 SHALL move RUN->DONE and set done=1 on the same edge.
REQ-026 Latency with res_valid held at 1: start sampled at edge E0; writes occur at edges E2..E257; done=1 after E257.
REQ-027 In DONE, done SHALL stay 1; DONE->IDLE SHALL occur when start=0, and done SHALL clear on the IDLE cycle.
REQ-028 start SHALL be ignored in LATCH, RUN and DONE; no restart is possible without passing through IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, pixel_cnt=0, done=0, busy=0, res_ready=0, wr_en=0, wr_addr=0, wr_data=0, mem_addr=0.
REQ-030 Reset mid-RUN SHALL abort the block with no further writes; the partial output is left as written.

Configuration
REQ-031 Macro MC_RECON_RESIDUAL_EN: when defined, the block behaves as specified above.
REQ-032 When MC_RECON_RESIDUAL_EN is undefined: res_data and res_valid are ignored; res_ready is held 0; every RUN cycle consumes a pixel with wr_data=mem_rdata (pure prediction copy); latency equals REQ-026.

Verification
REQ-033 Clamped MV copy: mb=(0,0), mv=(-5,+3), residual all 0, res_valid=1 -> reads start at ref_start_addr+3*352, 256 writes to dst_start_addr..(+15*352+15), done after edge 257.
REQ-034 Saturation: ref pixel 250 with res +20 -> wr_data 255; ref pixel 10 with res -30 -> wr_data 0; ref 100 with res -256 -> 0.
REQ-035 Frame edge: mb=(336,224), mv=(+12,+12) -> rx=336, ry=224; MV (+31,-32) -> clamped to (+16,-16).
REQ-036 Backpressure: res_valid toggled 1,0,0,1 on each pixel -> exactly 256 wr_en pulses in raster order, done after 256+2*256 RUN cycles+1.
REQ-037 Async reset asserted at pixel 100 -> wr_en low with no clock edge, state IDLE; a new start then runs all 256 pixels from pixel 0.
REQ-038 start held high through DONE -> done held at 1, no second run; start dropped -> IDLE and done=0 the next cycle.
